// File: rtl/gpio_protocol_pkg.sv
// Shared constants and state type for the GPIO nibble link receiver.
// Pin positions of the 6-bit GPIO bundle and the default frame length.
package gpio_protocol_pkg;

  localparam int DATA_LSB    = 0;
  localparam int SCLK_BIT    = 4;
  localparam int DONE_BIT    = 5;
  localparam int NIBBLE_W    = 4;
  localparam int GPIO_W      = 6;
  localparam int NIBBLES_DEF = 32;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for asynchronous GPIO inputs.
// Width is parameterised; all flops clear on synchronous reset.
module gpio_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_protocol_rx.sv
// GPIO nibble link receiver: frames NIBBLES nibbles into one word.
// Optional idle-abort of stalled frames under GPIO_RX_TIMEOUT_EN.
module gpio_protocol_rx
  import gpio_protocol_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NIBBLE_W-1:0]       gpio_data,
  input  logic                      gpio_sclk,
  input  logic                      gpio_done,
  output logic [NIBBLE_W*NIBBLES-1:0] msg_data,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int MW = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  logic [GPIO_W-1:0] pins;
  logic [GPIO_W-1:0] sync;

  always_comb begin
    pins = '0;
    pins[DATA_LSB +: NIBBLE_W] = gpio_data;
    pins[SCLK_BIT] = gpio_sclk;
    pins[DONE_BIT] = gpio_done;
  end

  gpio_sync2 #(
    .WIDTH(GPIO_W)
  ) u_sync (
    .clk_i(CLOCK_50),
    .rst_i(reset),
    .d_i  (pins),
    .q_o  (sync)
  );

  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [MW-1:0]     asm_q;
  logic [MW-1:0]     asm_d;
  logic [MW-1:0]     data_q;
  logic              valid_q;
  logic              err_q;
  logic              ovr_q;
  logic              sclk_d_q;
  logic              rise;
  logic              done;
  logic              is_last;
  logic [NIBBLE_W-1:0] nib;

`ifdef GPIO_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q;
`endif

  assign rise    = sync[SCLK_BIT] & ~sclk_d_q;
  assign done    = sync[DONE_BIT];
  assign nib     = sync[DATA_LSB +: NIBBLE_W];
  assign is_last = (cnt_q == LAST);

  // Assembly word with the current nibble merged into its slot
  always_comb begin
    asm_d = asm_q;
    asm_d[cnt_q*NIBBLE_W +: NIBBLE_W] = nib;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      asm_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      sclk_d_q <= 1'b0;
`ifdef GPIO_RX_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      sclk_d_q <= sync[SCLK_BIT];
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      if (valid_q && msg_ready) begin
        valid_q <= 1'b0;
      end
`ifdef GPIO_RX_TIMEOUT_EN
      if (state_q == RECV && cnt_q != '0 && !rise) begin
        idle_q <= idle_q + 1'b1;
      end else begin
        idle_q <= '0;
      end
`endif
      unique case (state_q)
        HUNT: begin
          if (rise && done) begin
            state_q <= RECV;
            cnt_q   <= '0;
          end
        end
        RECV: begin
          if (rise) begin
            asm_q <= asm_d;
            unique case (1'b1)
              (!is_last && !done): begin
                cnt_q <= cnt_q + 1'b1;
              end
              (!is_last && done): begin
                err_q <= 1'b1;
                cnt_q <= '0;
              end
              (is_last && done): begin
                cnt_q <= '0;
                // A same-cycle accept frees the output register
                if (!valid_q || msg_ready) begin
                  data_q  <= asm_d;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
              default: begin
                err_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= HUNT;
              end
            endcase
          end
`ifdef GPIO_RX_TIMEOUT_EN
          else if (idle_q == IW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= HUNT;
          end
`endif
        end
      endcase
    end
  end

  assign msg_data  = data_q;
  assign msg_valid = valid_q;
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_gpio_protocol_rx.sv
// Self-checking bench for gpio_protocol_rx (NIBBLES=32, TIMEOUT=16).
// Table vectors, hand sequences and a frame-level random model.
module tb_gpio_protocol_rx;

  localparam int NIB = 32;
  localparam int MW  = 4 * NIB;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [3:0]    gpio_data;
  logic          gpio_sclk;
  logic          gpio_done;
  logic [MW-1:0] msg_data;
  logic          msg_valid;
  logic          msg_ready;
  logic          frame_err;
  logic          overrun;

  always #10 CLOCK_50 = ~CLOCK_50;

  gpio_protocol_rx #(
    .NIBBLES(NIB),
    .TIMEOUT(16)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .gpio_data(gpio_data),
    .gpio_sclk(gpio_sclk),
    .gpio_done(gpio_done),
    .msg_data (msg_data),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_ovr  = 0;
  logic [MW-1:0] got_q[$];

  // Observe a quarter period before each rising edge
  always @(negedge CLOCK_50) begin
    #5;
    if (frame_err) n_err++;
    if (overrun) n_ovr++;
    if (msg_valid && msg_ready) got_q.push_back(msg_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [MW-1:0] act,
                     input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(int k, int mul, int add, int md);
    return 4'(((k * mul) + add) % md);
  endfunction

  function automatic logic [MW-1:0] pat_word(int mul, int add, int md);
    logic [MW-1:0] w;
    w = '0;
    for (int k = 0; k < NIB; k++) w[4*k +: 4] = pat(k, mul, add, md);
    return w;
  endfunction

  function automatic logic [MW-1:0] pack(logic [3:0] q[$]);
    logic [MW-1:0] w;
    w = '0;
    for (int k = 0; k < q.size(); k++) w[4*k +: 4] = q[k];
    return w;
  endfunction

  task automatic send(input logic [3:0] n, input logic d, input bit rdy);
    @(negedge CLOCK_50);
    gpio_data = n;
    gpio_done = d;
    @(negedge CLOCK_50);
    gpio_sclk = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    if (rdy) msg_ready = 1'b1;
    @(negedge CLOCK_50);
    if (rdy) msg_ready = 1'b0;
    gpio_sclk = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input int len, input bit end_done, input int mul,
                            input int add, input int md, input bit rdy_last);
    for (int k = 0; k < len; k++) begin
      send(pat(k, mul, add, md), end_done && (k == len - 1),
           rdy_last && (k == len - 1));
    end
  endtask

  typedef struct {
    int            len;
    bit            end_done;
    int            mul;
    int            add;
    int            md;
    int            exp_err;
    int            exp_msg;
    logic [MW-1:0] exp_word;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int e0, m0, o0;
    logic [MW-1:0] wa, wc;
    bit hunt;
    logic [3:0] cur[$];
    logic [MW-1:0] exp_q[$];
    int exp_err;

    tbl[0] = '{1, 1'b1, 0, 5, 16, 0, 0, '0};
    tbl[1] = '{32, 1'b1, 1, 0, 2, 0, 1, {16{8'h10}}};
    tbl[2] = '{5, 1'b1, 1, 3, 16, 1, 0, '0};
    tbl[3] = '{32, 1'b1, 1, 0, 16, 0, 1, pat_word(1, 0, 16)};
    tbl[4] = '{33, 1'b0, 1, 0, 16, 1, 0, '0};
    tbl[5] = '{1, 1'b1, 0, 9, 16, 0, 0, '0};
    tbl[6] = '{32, 1'b1, 7, 3, 16, 0, 1, pat_word(7, 3, 16)};
    tbl[7] = '{32, 1'b1, 3, 1, 16, 0, 1, pat_word(3, 1, 16)};

    reset = 1'b1;
    gpio_data = '0;
    gpio_sclk = 1'b0;
    gpio_done = 1'b0;
    msg_ready = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_valid", MW'(msg_valid), '0);
    chk("rst_data", msg_data, '0);
    chk("rst_ferr", MW'(frame_err), '0);
    chk("rst_ovr", MW'(overrun), '0);

    for (int i = 0; i < 8; i++) begin
      e0 = n_err;
      m0 = got_q.size();
      send_frame(tbl[i].len, tbl[i].end_done, tbl[i].mul, tbl[i].add,
                 tbl[i].md, 1'b0);
      chk($sformatf("vec%0d_ferr", i), MW'(n_err - e0), MW'(tbl[i].exp_err));
      chk($sformatf("vec%0d_msgs", i), MW'(got_q.size() - m0),
          MW'(tbl[i].exp_msg));
      if (tbl[i].exp_msg > 0)
        chk($sformatf("vec%0d_data", i), got_q[got_q.size()-1],
            tbl[i].exp_word);
      chk($sformatf("vec%0d_valid", i), MW'(msg_valid), '0);
    end

    // Overrun and same-cycle accept
    msg_ready = 1'b0;
    o0 = n_ovr;
    m0 = got_q.size();
    wa = pat_word(5, 2, 16);
    wc = pat_word(9, 4, 16);
    send_frame(32, 1'b1, 5, 2, 16, 1'b0);
    chk("ovr_a_valid", MW'(msg_valid), MW'(1));
    chk("ovr_a_data", msg_data, wa);
    send_frame(32, 1'b1, 3, 7, 16, 1'b0);
    chk("ovr_pulse", MW'(n_ovr - o0), MW'(1));
    chk("ovr_hold", msg_data, wa);
    chk("ovr_b_valid", MW'(msg_valid), MW'(1));
    send_frame(32, 1'b1, 9, 4, 16, 1'b1);
    chk("acc_no_ovr", MW'(n_ovr - o0), MW'(1));
    chk("acc_data", msg_data, wc);
    chk("acc_valid", MW'(msg_valid), MW'(1));
    chk("acc_taken", MW'(got_q.size() - m0), MW'(1));
    chk("acc_a_out", got_q[got_q.size()-1], wa);
    msg_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("acc_c_out", got_q[got_q.size()-1], wc);
    chk("acc_drain", MW'(msg_valid), '0);

    // Reset in the middle of a frame
    for (int k = 0; k < 10; k++) send(pat(k, 1, 1, 16), 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("mrst_data", msg_data, '0);
    chk("mrst_valid", MW'(msg_valid), '0);
    chk("mrst_ferr", MW'(frame_err), '0);
    reset = 1'b0;
    e0 = n_err;
    m0 = got_q.size();
    for (int k = 10; k < 32; k++) send(pat(k, 1, 1, 16), k == 31, 1'b0);
    chk("mrst_no_msg", MW'(got_q.size() - m0), '0);
    chk("mrst_no_err", MW'(n_err - e0), '0);
    send_frame(32, 1'b1, 11, 6, 16, 1'b0);
    chk("mrst_next_msgs", MW'(got_q.size() - m0), MW'(1));
    chk("mrst_next_data", got_q[got_q.size()-1], pat_word(11, 6, 16));

    // Stalled partial frame
    e0 = n_err;
    m0 = got_q.size();
    for (int k = 0; k < 3; k++) send(pat(k, 1, 0, 16), 1'b0, 1'b0);
    repeat (8) @(negedge CLOCK_50);
    chk("stall_early", MW'(n_err - e0), '0);
    repeat (20) @(negedge CLOCK_50);
`ifdef GPIO_RX_TIMEOUT_EN
    chk("stall_timeout", MW'(n_err - e0), MW'(1));
    send(4'h0, 1'b1, 1'b0);
    e0 = n_err;
    repeat (40) @(negedge CLOCK_50);
    chk("idle_cnt0", MW'(n_err - e0), '0);
    send_frame(32, 1'b1, 1, 0, 16, 1'b0);
`else
    chk("stall_wait", MW'(n_err - e0), '0);
    for (int k = 3; k < 32; k++) send(pat(k, 1, 0, 16), k == 31, 1'b0);
`endif
    chk("stall_msgs", MW'(got_q.size() - m0), MW'(1));
    chk("stall_data", got_q[got_q.size()-1], pat_word(1, 0, 16));

    // Random frames against a frame-level model
    hunt = 1'b0;
    cur.delete();
    exp_q.delete();
    exp_err = 0;
    e0 = n_err;
    m0 = got_q.size();
    for (int f = 0; f < 10; f++) begin
      int typ, len;
      bit dn;
      typ = int'($urandom_range(0, 3));
      len = (typ < 2) ? NIB :
            (typ == 2) ? int'($urandom_range(1, NIB - 1)) :
                         int'($urandom_range(NIB + 1, NIB + 8));
      dn = (typ != 3);
      for (int k = 0; k < len; k++) begin
        logic [3:0] nb;
        logic d;
        nb = 4'($urandom);
        d = dn && (k == len - 1);
        if (hunt) begin
          if (d) begin
            hunt = 1'b0;
            cur.delete();
          end
        end else begin
          cur.push_back(nb);
          if (d) begin
            if (cur.size() == NIB) exp_q.push_back(pack(cur));
            else exp_err++;
            cur.delete();
          end else if (cur.size() == NIB) begin
            exp_err++;
            hunt = 1'b1;
            cur.delete();
          end
        end
        send(nb, d, 1'b0);
      end
    end
    repeat (4) @(negedge CLOCK_50);
    chk("rnd_ferr", MW'(n_err - e0), MW'(exp_err));
    chk("rnd_msgs", MW'(got_q.size() - m0), MW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_data%0d", i), got_q[m0+i], exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
